// File: rtl/uart_tx_arbiter_if.sv
// Client/transmitter bundle for the UART TX arbiter.
// master = requesters plus the transmitter model; slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          rx_busy;
  logic                          tx_done;
  logic                          tx_send;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [ID_WIDTH-1:0]           grant_id;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            err;
  logic                          busy;

  modport master (
    output req, req_data, rx_busy, tx_done,
    input  tx_send, tx_data, grant_id, ack, err, busy
  );

  modport slave (
    input  req, req_data, rx_busy, tx_done,
    output tx_send, tx_data, grant_id, ack, err, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
//   state     | meaning
//   IDLE      | search for a winner when rx is quiet
//   LAUNCH    | tx_send pulse, timer cleared
//   WAIT_DONE | count until tx_done or timeout
//   RELEASE   | ack/err pulse, rotate priority
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input logic              clk,
  input logic              n_rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0]  TIMER_TC = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE} state_t;

  state_t                  state, state_nxt;
  logic [TIMER_W-1:0]      timer, timer_nxt;
  logic [ID_WIDTH-1:0]     last_grant, last_grant_nxt;
  logic [ID_WIDTH-1:0]     grant_q, grant_nxt;
  logic [DATA_WIDTH-1:0]   data_q, data_nxt;
  logic                    tx_send_q, tx_send_nxt;
  logic [NUM_REQ-1:0]      ack_q, ack_nxt;
  logic [NUM_REQ-1:0]      err_q, err_nxt;
  logic                    busy_q, busy_nxt;
  logic                    win_vld;
  logic [ID_WIDTH-1:0]     win_id;
  logic [ID_WIDTH-1:0]     cand;
  logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Walk from farthest to nearest so the requester just after last_grant wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= LAST_RST;
      grant_q    <= '0;
      data_q     <= '0;
      tx_send_q  <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      last_grant <= last_grant_nxt;
      grant_q    <= grant_nxt;
      data_q     <= data_nxt;
      tx_send_q  <= tx_send_nxt;
      ack_q      <= ack_nxt;
      err_q      <= err_nxt;
      busy_q     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (win_vld && !bus.rx_busy) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || timer == TIMER_TC) state_nxt = RELEASE;
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; tx_done takes precedence over the terminal count.
  always_comb begin
    tx_send_nxt    = 1'b0;
    ack_nxt        = '0;
    err_nxt        = '0;
    busy_nxt       = (state_nxt != IDLE);
    timer_nxt      = timer;
    last_grant_nxt = last_grant;
    grant_nxt      = grant_q;
    data_nxt       = data_q;
    case (state)
      IDLE: begin
        if (state_nxt == LAUNCH) begin
          grant_nxt   = win_id;
          data_nxt    = req_bytes[win_id];
          tx_send_nxt = 1'b1;
        end
      end
      LAUNCH: timer_nxt = '0;
      WAIT_DONE: begin
        if (timer != TIMER_TC) timer_nxt = timer + 1'b1;
        if (bus.tx_done) ack_nxt[grant_q] = 1'b1;
        else if (timer == TIMER_TC) err_nxt[grant_q] = 1'b1;
      end
      RELEASE: last_grant_nxt = grant_q;
      default: ;
    endcase
  end

  assign bus.tx_send  = tx_send_q;
  assign bus.tx_data  = data_q;
  assign bus.grant_id = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter between NUM_REQ byte requesters. It latches the winning requester's byte, launches it with a one-cycle tx_send pulse and waits for tx_done. It then acknowledges the requester, or flags an error if the transmitter times out. Transmission is half-duplex: a new byte is never launched while rx_busy is high. The block sits between the client logic and the UART TX datapath/controller.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, bits per UART byte
TIMEOUT_CYCLES, 2048, maximum WAIT_DONE cycles before abort (>=2)
ID_WIDTH, $clog2(NUM_REQ), width of grant_id (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester byte-valid level
req_data  input  NUM_REQ*DATA_WIDTH  flat bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
rx_busy  input  1  receive in progress; blocks new launches
tx_done  input  1  single-cycle pulse from transmitter: byte finished
tx_send  output  1  single-cycle launch pulse to transmitter
tx_data  output  DATA_WIDTH  latched byte, stable from tx_send until the next launch
grant_id  output  ID_WIDTH  index of current/last granted requester
ack  output  NUM_REQ  one-hot single-cycle pulse: byte sent
err  output  NUM_REQ  one-hot single-cycle pulse: transmit timeout
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous, any state:
  - Outputs: tx_send=0, tx_data=0, grant_id=0, ack=0, err=0, busy=0.
  - state=IDLE, timer=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE:
  - Winner search: if |req and !rx_busy, select the first i with req[i]=1, searching last_grant+1 .. last_grant+NUM_REQ modulo NUM_REQ.
  - On a win: latch grant_id<=i and tx_data<=req_data[i], then go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - tx_send=1; clear timer; go to WAIT_DONE.
  - Latency: req sampled in IDLE at cycle N gives tx_send high in cycle N+1.
- WAIT_DONE:
  - Timer increments every cycle from 0.
  - tx_done=1: go to RELEASE with ack result.
  - Else, if timer==TIMEOUT_CYCLES-1: go to RELEASE with err result.
  - tx_done at the terminal count wins: ack, not err.
- RELEASE (exactly 1 cycle):
  - ack[grant_id]=1, or err[grant_id]=1 on timeout.
  - last_grant<=grant_id; go to IDLE.
  - ack and err are never high together and never multi-bit.
- Minimum turnaround is 4 cycles per byte: IDLE, LAUNCH, one WAIT_DONE cycle, RELEASE.
- Requester handshake:
  - The requester holds req and its byte until ack/err.
  - It may drop req, or change its data, on the edge after seeing ack.
  - The byte is latched at grant; dropping req mid-transfer does not abort it, and ack/err is still issued.
- tx_done outside WAIT_DONE is ignored, including during LAUNCH.
- rx_busy is sampled only in IDLE; rx_busy rising mid-transfer does not abort.
- Timeout advances last_grant the same as success, so a stuck requester cannot starve the others.
- Timer width: $clog2(TIMEOUT_CYCLES). It saturates; no wrap inside WAIT_DONE.
- grant_id and tx_data hold their values in IDLE until the next grant.

Test Plan:
1. Single request:
   - Stimulus: after reset, req=4'b0010, req_data[15:8]=8'hA5, rx_busy=0; tx_done pulsed 10 cycles after tx_send.
   - Required: tx_send is 1 cycle wide, one cycle after the req sample; tx_data=8'hA5; grant_id=1; ack=4'b0010 exactly one cycle after tx_done; busy low again on the following cycle.
2. Round-robin fairness:
   - Stimulus: req=4'b1111 held; tx_done 3 cycles after each tx_send.
   - Required: grant order 0,1,2,3,0,1; no requester is served twice before the others.
3. Half-duplex hold-off:
   - Stimulus: req=4'b0001 with rx_busy=1 for 20 cycles, then rx_busy=0.
   - Required: no tx_send while rx_busy is high; tx_send one cycle after the first IDLE cycle with rx_busy=0.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, req=4'b0101, tx_done never pulsed for requester 0.
   - Required: err=4'b0001 at cycle tx_send+17; ack stays 0; next tx_send serves requester 2 with its byte.
5. Tie at the terminal count:
   - Stimulus: TIMEOUT_CYCLES=16, tx_done asserted in the 16th WAIT_DONE cycle.
   - Required: ack pulses, err=0.
6. Reset mid-transfer:
   - Stimulus: assert n_rst=0 during WAIT_DONE while req=4'b1110 was granted to 2; release reset with req=4'b1111.
   - Required: all outputs 0 immediately; first post-reset grant_id=0.
